// File: rtl/scr30b_tx.sv
// scr30b_tx: 30-bit self-synchronizing scrambler (G = x^58 + x^39 + 1) with a 2-deep input FIFO and idle fill.
// Define SCR30B_BYPASS_EN to add a BYPASS input that sends the raw word unscrambled.
module scr30b_tx (
   input  logic        CLK,
   input  logic        RST,
   input  logic [29:0] DataIn,
   input  logic        DataInValid,
   output logic        DataInReady,
   input  logic        REV,
   input  logic        TxReady,
`ifdef SCR30B_BYPASS_EN
   input  logic        BYPASS,
`endif
   output logic [29:0] DataOut,
   output logic [15:0] IdleCnt
);
   localparam logic [57:0] SEED = 58'h155_5557_5555_5555;

   logic [29:0] mem_q [2];
   logic        wr_q, rd_q, rdy_q, rdy_d, push, pop, bypass;
   logic [1:0]  cnt_q, cnt_d;
   logic [57:0] s_q, s_d;
   logic [29:0] dout_q, dout_d, w, o, o_rev;
   logic [15:0] idle_q, idle_d;

`ifdef SCR30B_BYPASS_EN
   assign bypass = BYPASS;
`else
   assign bypass = 1'b0;
`endif

   // O[i] uses the history as it stood before this word; the history then shifts in O with bit 29 newest
   for (genvar g = 0; g < 30; g++) begin : g_scr
      assign o[g]        = w[g] ^ s_q[57-g] ^ s_q[38-g];
      assign o_rev[29-g] = o[g];
   end

   always_comb begin
      push   = DataInValid && rdy_q;
      pop    = TxReady && (cnt_q != 2'd0);
      w      = (pop ? mem_q[rd_q] : 30'h0) ^ {30{REV}};
      dout_d = TxReady ? (bypass ? w : o) : dout_q;
      s_d    = (TxReady && !bypass) ? {s_q[27:0], o_rev} : s_q;
      idle_d = (TxReady && !pop && idle_q != 16'hFFFF) ? idle_q + 16'd1 : idle_q;
      cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
      rdy_d  = cnt_d != 2'd2;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_q   <= 1'b0;
         rd_q   <= 1'b0;
         cnt_q  <= 2'd0;
         rdy_q  <= 1'b0;
         s_q    <= SEED;
         dout_q <= 30'h0;
         idle_q <= 16'h0;
      end else begin
         wr_q   <= wr_q ^ push;
         rd_q   <= rd_q ^ pop;
         cnt_q  <= cnt_d;
         rdy_q  <= rdy_d;
         s_q    <= s_d;
         dout_q <= dout_d;
         idle_q <= idle_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (push) mem_q[wr_q] <= DataIn;
   end

   assign DataInReady = rdy_q;
   assign DataOut     = dout_q;
   assign IdleCnt     = idle_q;
endmodule

// File: tb/tb_scr30b_tx.sv
// tb_scr30b_tx: random and directed checks of scr30b_tx against a bit-serial line model and loopback descrambler.
module tb_scr30b_tx;
   logic        CLK = 1'b0;
   logic        RST, DataInValid, DataInReady, REV, TxReady;
   logic [29:0] DataIn, DataOut;
   logic [15:0] IdleCnt;

   localparam logic [57:0] SEED = 58'h155_5557_5555_5555;

   int          nchk = 0, nerr = 0, n_acc = 0;
   bit          tx_line[$], rx_line[$];
   logic [29:0] m_q[$];
   logic        m_rdy;
   logic [29:0] m_dout, last_rec;
   logic [15:0] m_idle;

   always #5 CLK = ~CLK;

   scr30b_tx dut (
      .CLK(CLK), .RST(RST), .DataIn(DataIn), .DataInValid(DataInValid),
      .DataInReady(DataInReady), .REV(REV), .TxReady(TxReady),
`ifdef SCR30B_BYPASS_EN
      .BYPASS(1'b0),
`endif
      .DataOut(DataOut), .IdleCnt(IdleCnt)
   );

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // line history holds the last 58 bits on the wire, oldest first
   task automatic model_reset();
      logic [57:0] sd;
      sd = SEED;
      tx_line = {};
      rx_line = {};
      for (int j = 57; j >= 0; j--) begin
         tx_line.push_back(sd[j]);
         rx_line.push_back(sd[j]);
      end
      m_q = {};
      m_rdy = 1'b0;
      m_dout = 30'h0;
      m_idle = 16'h0;
   endtask

   task automatic tx_scramble(input logic [29:0] w, output logic [29:0] o);
      for (int i = 0; i < 30; i++) begin
         o[i] = w[i] ^ tx_line[0] ^ tx_line[19];
         tx_line.push_back(o[i]);
         void'(tx_line.pop_front());
      end
   endtask

   task automatic rx_descramble(input logic [29:0] o, input logic rev, output logic [29:0] w);
      for (int i = 0; i < 30; i++) begin
         w[i] = o[i] ^ rx_line[0] ^ rx_line[19] ^ rev;
         rx_line.push_back(o[i]);
         void'(rx_line.pop_front());
      end
   endtask

   task automatic cyc(input logic v, input logic [29:0] d, input logic tr, input logic rev);
      logic [29:0] raw, rec;
      logic        psh;
      DataInValid = v;
      DataIn = d;
      TxReady = tr;
      REV = rev;
      @(posedge CLK);
      psh = v && m_rdy;
      raw = 30'h0;
      if (tr) begin
         if (m_q.size() > 0) raw = m_q.pop_front();
         else if (m_idle != 16'hFFFF) m_idle++;
         tx_scramble(raw ^ {30{rev}}, m_dout);
      end
      if (psh) begin
         m_q.push_back(d);
         n_acc++;
      end
      m_rdy = m_q.size() < 2;
      #1;
      nchk++;
      if (DataOut !== m_dout) begin
         nerr++;
         $display("FAIL dataout: got %h expected %h", DataOut, m_dout);
      end
      nchk++;
      if (DataInReady !== m_rdy) begin
         nerr++;
         $display("FAIL ready: got %b expected %b", DataInReady, m_rdy);
      end
      nchk++;
      if (IdleCnt !== m_idle) begin
         nerr++;
         $display("FAIL idlecnt: got %h expected %h", IdleCnt, m_idle);
      end
      if (tr) begin
         rx_descramble(DataOut, rev, rec);
         last_rec = rec;
         nchk++;
         if (rec !== raw) begin
            nerr++;
            $display("FAIL loopback: got %h expected %h", rec, raw);
         end
      end
   endtask

   task automatic pulse_reset();
      DataInValid = 1'b0;
      TxReady = 1'b0;
      RST = 1'b1;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      DataInValid = 1'b0;
      DataIn = 30'h0;
      TxReady = 1'b0;
      REV = 1'b0;
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      nchk++;
      if (DataOut !== 30'h0) begin nerr++; $display("FAIL reset_dout: got %h expected 0", DataOut); end
      nchk++;
      if (DataInReady !== 1'b0) begin nerr++; $display("FAIL reset_ready: got %b expected 0", DataInReady); end
      nchk++;
      if (IdleCnt !== 16'h0) begin nerr++; $display("FAIL reset_idle: got %h expected 0", IdleCnt); end
      RST = 1'b0;
      model_reset();
      cyc(1'b0, 30'h0, 1'b0, 1'b0);
      nchk++;
      if (DataInReady !== 1'b1) begin nerr++; $display("FAIL ready_after_reset: got %b expected 1", DataInReady); end
   endtask

   task automatic test_idle();
      repeat (100) cyc(1'b0, 30'h0, 1'b1, 1'b0);
      nchk++;
      if (IdleCnt !== 16'd100) begin nerr++; $display("FAIL idle100: got %0d expected 100", IdleCnt); end
   endtask

   task automatic test_random();
      int start, n;
      start = n_acc;
      n = 0;
      while (n_acc - start < 1000 && n < 6000) begin
         cyc(1'($urandom_range(0, 1)), 30'($urandom), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 9) == 0));
         n++;
      end
      repeat (3) cyc(1'b0, 30'h0, 1'b1, 1'b0);
      nchk++;
      if (n_acc - start != 1000) begin nerr++; $display("FAIL random_accept: got %0d expected 1000", n_acc - start); end
   endtask

   task automatic test_back_to_back();
      logic [29:0] a, b, c, d0;
      a = 30'h0123_4567;
      b = 30'h3EDC_BA98;
      c = 30'h1555_0AAA;
      d0 = DataOut;
      cyc(1'b1, a, 1'b0, 1'b0);
      cyc(1'b1, b, 1'b0, 1'b0);
      repeat (3) cyc(1'b1, c, 1'b0, 1'b0);
      nchk++;
      if (DataOut !== d0) begin nerr++; $display("FAIL b2b_hold: got %h expected %h", DataOut, d0); end
      nchk++;
      if (DataInReady !== 1'b0) begin nerr++; $display("FAIL b2b_full: got %b expected 0", DataInReady); end
      cyc(1'b1, c, 1'b1, 1'b0);
      nchk++;
      if (last_rec !== a) begin nerr++; $display("FAIL b2b_a: got %h expected %h", last_rec, a); end
      cyc(1'b1, c, 1'b1, 1'b0);
      nchk++;
      if (last_rec !== b) begin nerr++; $display("FAIL b2b_b: got %h expected %h", last_rec, b); end
      cyc(1'b0, 30'h0, 1'b1, 1'b0);
      nchk++;
      if (last_rec !== c) begin nerr++; $display("FAIL b2b_c: got %h expected %h", last_rec, c); end
   endtask

   task automatic test_rev();
      cyc(1'b1, 30'h2AAA_AAAA, 1'b1, 1'b1);
      nchk++;
      if (last_rec !== 30'h0) begin nerr++; $display("FAIL rev_idle: got %h expected 0", last_rec); end
      cyc(1'b0, 30'h0, 1'b1, 1'b1);
      nchk++;
      if (last_rec !== 30'h2AAA_AAAA) begin nerr++; $display("FAIL rev_payload: got %h expected 2aaaaaaa", last_rec); end
   endtask

   task automatic test_reset_mid();
      cyc(1'b1, 30'h1111_1111, 1'b0, 1'b0);
      cyc(1'b1, 30'h2222_2222, 1'b0, 1'b0);
      DataInValid = 1'b0;
      RST = 1'b1;
      #2;
      nchk++;
      if (DataOut !== 30'h0) begin nerr++; $display("FAIL midrst_dout: got %h expected 0", DataOut); end
      nchk++;
      if (DataInReady !== 1'b0) begin nerr++; $display("FAIL midrst_ready: got %b expected 0", DataInReady); end
      @(posedge CLK);
      #1;
      nchk++;
      if (IdleCnt !== 16'h0) begin nerr++; $display("FAIL midrst_idle: got %h expected 0", IdleCnt); end
      RST = 1'b0;
      model_reset();
      repeat (5) cyc(1'b0, 30'h0, 1'b1, 1'b0);
   endtask

   task automatic test_saturate();
      pulse_reset();
      repeat (65534) cyc(1'b0, 30'h0, 1'b1, 1'b0);
      nchk++;
      if (IdleCnt !== 16'hFFFE) begin nerr++; $display("FAIL sat_fffe: got %h expected fffe", IdleCnt); end
      repeat (3) cyc(1'b0, 30'h0, 1'b1, 1'b0);
      nchk++;
      if (IdleCnt !== 16'hFFFF) begin nerr++; $display("FAIL sat_ffff: got %h expected ffff", IdleCnt); end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_random();
      test_back_to_back();
      test_rev();
      test_reset_mid();
      test_saturate();
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule

// File: doc/scr30b_tx.md
SCR30B_TX -- requirements
Module: scr30b_tx

Interface
REQ-001 CLK  input  1  sole clock; all state on rising edge.
REQ-002 RST  input  1  asynchronous, active-high reset.
REQ-003 DataIn  input  30  raw payload word; bit 0 transmitted first.
REQ-004 DataInValid  input  1  DataIn holds a word to send.
REQ-005 DataInReady  output  1  block accepts DataIn this cycle.
REQ-006 REV  input  1  1 = bitwise-invert raw word (payload and idle) before scrambling.
REQ-007 TxReady  input  1  downstream gearbox consumes DataOut this cycle.
REQ-008 DataOut  output  30  registered scrambled word.
REQ-009 IdleCnt  output  16  count of idle words transmitted.

Function
REQ-010 Polynomial G = X^58 + X^39 + 1, self-synchronizing, with 58-bit history register S of previously transmitted scrambled bits; S[0] = most recent bit.
REQ-011 Scrambled word: O[i] = W[i] ^ S[57-i] ^ S[38-i], i = 0..29, where W = selected raw word after REV.
REQ-012 History update on each load: S'[k] = O[29-k] for k = 0..29; S'[k] = S[k-30] for k = 30..57.
REQ-013 Input buffer: 2-entry FIFO; push when DataInValid && DataInReady; DataInReady = not full (registered).
REQ-014 On TxReady = 1 edge: if FIFO non-empty, pop head as W; else W = idle word 30'h0; load DataOut = O and update S.
REQ-015 On TxReady = 0 edge: DataOut, S, and FIFO head hold; pushes still allowed while not full.
REQ-016 Push and pop on same edge: both take effect; occupancy unchanged.
REQ-017 Latency: word accepted at edge k appears on DataOut at edge k+1 at earliest (FIFO empty, TxReady = 1 at k+1); ordering preserved.
REQ-018 Word pushed at edge k is not poppable at edge k (no FIFO fall-through).
REQ-019 IdleCnt increments by 1 per idle word loaded; saturates at 16'hFFFF; no wrap.
REQ-020 REV is sampled at load time, not at push time.

Reset
REQ-021 While RST high: DataOut = 30'h0, S = 58'h155_5557_5555_5555, FIFO empty, IdleCnt = 0, DataInReady = 0.
REQ-022 First edge after RST deasserts: DataInReady = 1.
REQ-023 RST asserted mid-stream discards all buffered words, and the seed is restored immediately (asynchronously).

Configuration
REQ-024 Macro SCR30B_BYPASS_EN, when defined: adds input BYPASS (1 bit).
REQ-025 BYPASS = 1: DataOut loads W unscrambled; S holds; FIFO, idle, and IdleCnt behaviour unchanged.
REQ-026 Macro undefined: no BYPASS port; always scrambled.

Verification
REQ-027 Reset, TxReady = 1, DataInValid = 0 for 100 cycles -> IdleCnt = 100; loopback into the matching descrambler (same seed, same reset, REV = 0) recovers 30'h0 from the first word.
REQ-028 1000 random words, TxReady random 50% -> loopback descrambler output equals the accepted sequence exactly, in order, no loss or duplication.
REQ-029 TxReady = 0 for 5 cycles, DataInValid = 1 with words A, B, C -> A and B accepted, DataInReady = 0, DataOut constant; TxReady = 1 -> A then B then C on consecutive cycles.
REQ-030 REV = 1 both ends, payload 30'h2AAAAAAA -> recovered 30'h2AAAAAAA; idle word on the line equals the scramble of 30'h3FFFFFFF.
REQ-031 Force IdleCnt to 16'hFFFE via 65534 idle cycles, then 3 more -> IdleCnt = 16'hFFFF, stays.
REQ-032 RST pulse mid-stream with FIFO holding 2 words -> DataOut = 0, DataInReady = 0 during reset, buffered words never emitted; the post-reset stream matches the golden model from the seed.
